conv1d_mc: RTL
==============

Name: conv1d_mc

Overview:
Parametrised multi-channel 1-D FIR convolution engine for the I2S audio path; it succeeds the single-channel fixed-kernel conv1d. It sits between sipo and piso and filters every channel with one shared, runtime-loadable signed kernel. It uses a sequential MAC, one tap per cycle, with all channels processed in parallel. Both sides use ready/valid handshakes.

Parameters:
width_p, 24, signed sample width per channel
channels_p, 2, channel count; channel c occupies data bits [c*width_p +: width_p], channel 0 = left
depth_p, 8, number of taps (>=2)
coeff_width_p, 8, signed coefficient width
frac_p, 7, coefficient fractional bits (1.0 = 1<<frac_p)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; synchronous, active-low
valid_i  in  1  input sample-set valid
ready_o  out  1  input ready
data_i  in  channels_p*width_p  packed signed input samples
valid_o  out  1  output valid
ready_i  in  1  downstream ready
data_o  out  channels_p*width_p  packed signed filtered samples
coef_v_i  in  1  coefficient write valid
coef_ready_o  out  1  coefficient write ready
coef_addr_i  in  $clog2(depth_p)  tap index
coef_data_i  in  coeff_width_p  signed coefficient

Behaviour:
- Reset (reset_n_i low at a clk_i edge):
  - state=IDLE, valid_o=0, data_o=0.
  - Delay lines all zero.
  - Coefficients: h[0]=1<<frac_p, others 0 (identity).
  - Accumulators zero.
  - Reset mid-MAC or mid-DONE aborts the operation; the pending output is discarded.
- FSM states IDLE, MAC, DONE:
  - IDLE: ready_o=1, coef_ready_o=1.
    - On valid_i&ready_o, shift each channel's delay line (x[k]<=x[k-1], x[0]<=data_i channel), clear the accumulators, tap counter=0, go to MAC.
  - MAC: one cycle per tap k=0..depth_p-1; acc_c += h[k]*x_c[k], signed full precision.
    - After tap depth_p-1, register the outputs and go to DONE.
    - ready_o=0, coef_ready_o=0.
  - DONE: valid_o=1 and data_o holds stable until ready_i.
    - On valid_o&ready_i, go to IDLE; valid_o=0 the next cycle.
    - ready_o=0 throughout; the next input is accepted no earlier than the cycle after the output handshake.
- Latency and throughput:
  - valid_o rises depth_p+1 cycles after the input handshake cycle.
  - Minimum period between accepts is depth_p+2 cycles.
- Arithmetic:
  - Accumulator width = width_p+coeff_width_p+$clog2(depth_p).
  - Result = acc >>> frac_p (arithmetic shift; truncation toward -inf).
  - Saturated to [-2^(width_p-1), 2^(width_p-1)-1] per channel independently.
- Coefficient writes:
  - A write occurs on coef_v_i&coef_ready_o (IDLE only) and updates h[coef_addr_i] at the clock edge.
  - Writes offered in MAC/DONE are not taken; the source must hold them.
  - A write and a sample accept in the same IDLE cycle are both taken; the new coefficient applies to that sample.
- Error cases:
  - coef_addr_i >= depth_p (non-power-of-2 depth) is ignored; no coefficient changes.
  - valid_i while ready_o=0 has no effect.
- Continuity: delay-line contents persist across samples; only reset clears them.

Test Plan:
1. Identity default: after reset, send ch0=1000, ch1=-5 -> data_o ch0=1000, ch1=-5; valid_o rises exactly 9 cycles after the accept (depth_p=8).
2. Moving average: write h0..h3=32, h4..h7=0; send ch0 impulse 400 then four zeros -> outputs 100,100,100,100,0; ch1 driven 0 -> all 0.
3. Saturation:
   - h0=h1=127; send 0x7FFFFF twice -> 8323071 then 0x7FFFFF (clamped).
   - Send 0x800000 twice -> second output 0x800000.
4. Rounding: h0=64, others 0; input -3 -> -2; input 3 -> 1.
5. Backpressure/handshake: hold ready_i=0 for 20 cycles in DONE, toggling valid_i and coef_v_i -> valid_o and data_o stable, ready_o=0, coef_ready_o=0, no sample or coefficient taken; release -> one handshake, then ready_o=1 the next cycle.
6. Reset mid-operation: assert reset_n_i=0 for one cycle during MAC tap 3 -> valid_o never pulses for that sample; next input 77 returns 77 (identity restored, delay line zeroed).

Source files
------------

// File: rtl/conv1d_mc.sv
// Multi-channel 1-D FIR: every channel is filtered with one shared, runtime-loadable signed kernel.
// Latency: valid_o rises depth_p+1 cycles after the input handshake; one tap per cycle, all channels in parallel.
// Backpressure: ready_o/coef_ready_o are high only in IDLE; the result holds in DONE until ready_i.
//
// Ports:
//   clk_i, reset_n_i               clock, synchronous active-low reset
//   valid_i/ready_o/data_i         input sample set; channel c is data_i[c*width_p +: width_p]
//   valid_o/ready_i/data_o         filtered sample set, same packing, saturated per channel
//   coef_v_i/coef_ready_o          coefficient write handshake (taken in IDLE only)
//   coef_addr_i/coef_data_i        tap index and signed coefficient value
module conv1d_mc #(
  parameter int width_p       = 24,
  parameter int channels_p    = 2,
  parameter int depth_p       = 8,
  parameter int coeff_width_p = 8,
  parameter int frac_p        = 7
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [channels_p*width_p-1:0]    data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [channels_p*width_p-1:0]    data_o,
  input  logic                             coef_v_i,
  output logic                             coef_ready_o,
  input  logic [$clog2(depth_p)-1:0]       coef_addr_i,
  input  logic [coeff_width_p-1:0]         coef_data_i
);

  localparam int tap_w_lp = $clog2(depth_p);
  localparam int acc_w_lp = width_p + coeff_width_p + tap_w_lp;
  // The reset kernel is +1.0 (1<<frac_p), which is one bit beyond a
  // coeff_width_p signed value, so each coefficient register keeps one
  // extra sign bit. Written coefficients are sign-extended into it.
  localparam int h_w_lp = coeff_width_p + 1;

  localparam logic signed [h_w_lp-1:0] one_lp = h_w_lp'(1) << frac_p;
  localparam logic signed [acc_w_lp-1:0] sat_max_lp =
    {{(acc_w_lp-width_p+1){1'b0}}, {(width_p-1){1'b1}}};
  localparam logic signed [acc_w_lp-1:0] sat_min_lp =
    {{(acc_w_lp-width_p+1){1'b1}}, {(width_p-1){1'b0}}};
  localparam logic [tap_w_lp-1:0] last_tap_lp = tap_w_lp'(depth_p - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                      state_q;
  logic signed [width_p-1:0]   x_q   [channels_p][depth_p];
  logic signed [h_w_lp-1:0]    h_q   [depth_p];
  logic signed [acc_w_lp-1:0]  acc_q [channels_p];
  logic [tap_w_lp-1:0]         tap_q;

  logic signed [acc_w_lp-1:0]  acc_nxt [channels_p];
  logic [channels_p*width_p-1:0] sat_dat;

  assign ready_o      = (state_q == IDLE);
  assign coef_ready_o = (state_q == IDLE);

  // Current-tap MAC and the saturated result of the final sum. Operands are
  // sign-extended to the accumulator width first, so the low acc_w_lp bits
  // of the unsigned product equal the exact signed product.
  always_comb begin
    logic [acc_w_lp-1:0]        h_ext;
    logic [acc_w_lp-1:0]        x_ext;
    logic signed [acc_w_lp-1:0] prod;
    logic signed [acc_w_lp-1:0] sh;
    sat_dat = '0;
    h_ext   = '0;
    x_ext   = '0;
    prod    = '0;
    sh      = '0;
    for (int c = 0; c < channels_p; c++) begin
      h_ext      = {{(acc_w_lp-h_w_lp){h_q[tap_q][h_w_lp-1]}}, h_q[tap_q]};
      x_ext      = {{(acc_w_lp-width_p){x_q[c][tap_q][width_p-1]}}, x_q[c][tap_q]};
      prod       = h_ext * x_ext;
      acc_nxt[c] = acc_q[c] + prod;
      sh         = acc_nxt[c] >>> frac_p;  // floor toward -inf
      if (sh > sat_max_lp)
        sat_dat[c*width_p +: width_p] = sat_max_lp[width_p-1:0];
      else if (sh < sat_min_lp)
        sat_dat[c*width_p +: width_p] = sat_min_lp[width_p-1:0];
      else
        sat_dat[c*width_p +: width_p] = sh[width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
      tap_q   <= '0;
      for (int c = 0; c < channels_p; c++) begin
        acc_q[c] <= '0;
        for (int k = 0; k < depth_p; k++) x_q[c][k] <= '0;
      end
      for (int k = 0; k < depth_p; k++) h_q[k] <= (k == 0) ? one_lp : '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Addresses past the last tap (non-power-of-2 depth) are dropped.
          if (coef_v_i && (int'(coef_addr_i) < depth_p))
            h_q[coef_addr_i] <= {coef_data_i[coeff_width_p-1], coef_data_i};
          if (valid_i) begin
            for (int c = 0; c < channels_p; c++) begin
              x_q[c][0] <= data_i[c*width_p +: width_p];
              for (int k = 1; k < depth_p; k++) x_q[c][k] <= x_q[c][k-1];
              acc_q[c] <= '0;
            end
            tap_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          for (int c = 0; c < channels_p; c++) acc_q[c] <= acc_nxt[c];
          tap_q <= tap_q + tap_w_lp'(1);
          if (tap_q == last_tap_lp) begin
            data_o  <= sat_dat;
            valid_o <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
